cache_fill_fsm: RTL

- Miss-handling controller that sits directly upstream of the 16-bit byte-addressable data memory.
- On a cache miss it fetches the whole 16-byte block (8 words) from the memory and streams each returned word into the cache data array.
- When the last word arrives it writes the tag array.
- It drives the memory's pipelined, fixed-latency request port and tracks issued and received words independently.

---
 rtl/cache_fill_fsm_pkg.sv | 17 +
 rtl/cache_fill_fsm_if.sv | 32 +++
 rtl/cache_fill_fsm_fill_counter.sv | 38 +++
 rtl/cache_fill_fsm.sv | 113 +++++++++++
 4 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// Shared types and block-geometry constants for the cache miss fill controller.
// The block is 16 bytes, which is 8 words of 16 bits.
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int unsigned BLOCK_BYTES     = 16;
  localparam int unsigned WORDS_PER_BLOCK = 8;
  localparam int unsigned OFFSET_BITS     = 4;
  localparam int unsigned WORD_IDX_BITS   = 3;
  // One bit wider than the word index so that "all 8 done" is representable.
  localparam int unsigned CNT_BITS        = WORD_IDX_BITS + 1;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Cache/memory side signals of the fill controller.
// The master modport is the fill FSM; the slave modport is the cache plus memory.
interface cache_fill_fsm_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  import cache_pkg::*;

  logic                     miss_detected;
  logic [ADDR_WIDTH-1:0]    miss_address;
  logic                     fsm_busy;
  logic                     memory_req;
  logic [ADDR_WIDTH-1:0]    memory_address;
  logic [15:0]              memory_data;
  logic                     memory_data_valid;
  logic                     write_data_array;
  logic [WORD_IDX_BITS-1:0] fill_word;
  logic [15:0]              fill_data;
  logic                     write_tag_array;

  modport master (
    input  miss_detected, miss_address, memory_data, memory_data_valid,
    output fsm_busy, memory_req, memory_address,
    output write_data_array, fill_word, fill_data, write_tag_array
  );

  modport slave (
    output miss_detected, miss_address, memory_data, memory_data_valid,
    input  fsm_busy, memory_req, memory_address,
    input  write_data_array, fill_word, fill_data, write_tag_array
  );

endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// Saturating word counter used for both issued requests and received words.
// Clear wins over enable; the count sticks at LIMIT, which raises done_o.
module fill_counter
  import cache_pkg::*;
#(
  parameter int unsigned LIMIT = WORDS_PER_BLOCK
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                en_i,
  output logic [CNT_BITS-1:0] count_o,
  output logic                done_o
);

  logic [CNT_BITS-1:0] count_q, count_d;

  assign done_o  = (count_q == CNT_BITS'(LIMIT));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !done_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss fill controller: issues 8 pipelined word reads for the missing block,
// streams each returned word into the data array, then writes the tag.
module cache_fill_fsm #(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned MEM_LATENCY     = 4
) (
  input logic              clk,
  input logic              rst,
  cache_fill_fsm_if.master bus
);
  import cache_pkg::*;

  // The FSM counts valids rather than cycles, so the memory latency never enters the logic.
  localparam int unsigned unused_mem_latency = MEM_LATENCY;

  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(BLOCK_BYTES - 1);
  localparam logic [CNT_BITS-1:0]   LAST_WORD   = CNT_BITS'(WORDS_PER_BLOCK - 1);

  fill_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;

  logic                cnt_clr;
  logic                issue_en, recv_en;
  logic                issue_done, recv_done;
  logic [CNT_BITS-1:0] issue_cnt, recv_cnt;
  logic [CNT_BITS-1:0] issue_off;

  logic busy, req, wr, tag;

  fill_counter #(.LIMIT(WORDS_PER_BLOCK)) u_issue_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .en_i    (issue_en),
    .count_o (issue_cnt),
    .done_o  (issue_done)
  );

  fill_counter #(.LIMIT(WORDS_PER_BLOCK)) u_recv_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .en_i    (recv_en),
    .count_o (recv_cnt),
    .done_o  (recv_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    cnt_clr  = 1'b0;
    issue_en = 1'b0;
    recv_en  = 1'b0;
    busy     = 1'b0;
    req      = 1'b0;
    wr       = 1'b0;
    tag      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.miss_detected) begin
          base_d  = bus.miss_address & ~OFFSET_MASK;
          cnt_clr = 1'b1;
          state_d = FILL;
        end
      end

      FILL: begin
        busy = 1'b1;
        if (!issue_done) begin
          req      = 1'b1;
          issue_en = 1'b1;
        end
        // Responses are tracked independently of requests; only the count matters.
        if (bus.memory_data_valid && !recv_done) begin
          wr      = 1'b1;
          recv_en = 1'b1;
          if (recv_cnt == LAST_WORD) begin
            tag     = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Once all requests are out the address freezes on the final word of the block.
  assign issue_off = issue_done ? LAST_WORD : issue_cnt;

  assign bus.fsm_busy         = busy;
  assign bus.memory_req       = req;
  assign bus.memory_address   = base_q + ADDR_WIDTH'({issue_off, 1'b0});
  assign bus.write_data_array = wr;
  assign bus.fill_word        = wr ? recv_cnt[WORD_IDX_BITS-1:0] : '0;
  assign bus.fill_data        = wr ? bus.memory_data : '0;
  assign bus.write_tag_array  = tag;

endmodule
